x64_ser: RTL

//  Transmit-side counterpart of the 64-bit-pair byte deserializer: takes a pair of 64-bit words
//  (a, b) and emits them as a 16-byte frame, one byte per clk, MSB-first starting at b[63:56],

---
 rtl/x64_ser.sv | 111 +++++++++++
 1 files changed

// File: rtl/x64_ser.sv
// x64_ser: serializes a 64-bit word pair {b,a} into a free-running frame of bytes, MSB of b first.
// Optional build macro X64_SER_CHECKSUM_EN appends an XOR checksum slot (17-slot frame).
module x64_ser #(
  parameter int HALF_W = 64,
  parameter int BYTE_W = 8,
`ifdef X64_SER_CHECKSUM_EN
  localparam int SLOTS = 2 * HALF_W / BYTE_W + 1,
`else
  localparam int SLOTS = 2 * HALF_W / BYTE_W,
`endif
  localparam int CNT_W = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HALF_W-1:0] data_i_a,
  input  logic [HALF_W-1:0] data_i_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] data_o,
  output logic              byte_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic [CNT_W-1:0]  cnt
);

  localparam int PAIR_W = 2 * HALF_W;
  localparam int SREG_W = SLOTS * BYTE_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOTS - 1);

  localparam logic IDLE_FRAME = 1'b0;
  localparam logic DATA_FRAME = 1'b1;

  logic [SREG_W-1:0] sreg;
  logic [SREG_W-1:0] load_val;
  logic [HALF_W-1:0] hold_a;
  logic [HALF_W-1:0] hold_b;
  logic              hold_full;
  logic              armed;
  logic              state;
  logic              load_now;
  logic              accept;

`ifdef X64_SER_CHECKSUM_EN
  function automatic logic [BYTE_W-1:0] xor_bytes(input logic [PAIR_W-1:0] p);
    logic [BYTE_W-1:0] x;
    x = '0;
    for (int unsigned i = 0; i < PAIR_W / BYTE_W; i++)
      x ^= p[i*BYTE_W +: BYTE_W];
    return x;
  endfunction
`endif

  assign load_now   = armed && (cnt == LAST);
  assign in_ready   = !hold_full || load_now;
  assign accept     = in_valid && in_ready;
  assign data_o     = sreg[SREG_W-1 -: BYTE_W];
  assign byte_valid = (state == DATA_FRAME);

  always_comb begin
    load_val = '0;
    if (hold_full) begin
`ifdef X64_SER_CHECKSUM_EN
      load_val = {hold_b, hold_a, xor_bytes({hold_b, hold_a})};
`else
      load_val = {hold_b, hold_a};
`endif
    end
  end

  // The first edge after reset release opens slot 0 without advancing cnt,
  // so every frame, including the first, begins with frame_start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      sreg        <= '0;
      hold_a      <= '0;
      hold_b      <= '0;
      hold_full   <= 1'b0;
      armed       <= 1'b0;
      state       <= IDLE_FRAME;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      if (accept) begin
        hold_a    <= data_i_a;
        hold_b    <= data_i_b;
        hold_full <= 1'b1;
      end else if (load_now) begin
        hold_full <= 1'b0;
      end

      if (!armed) begin
        armed       <= 1'b1;
        frame_start <= 1'b1;
        frame_done  <= 1'b0;
      end else if (load_now) begin
        cnt         <= '0;
        sreg        <= load_val;
        state       <= hold_full ? DATA_FRAME : IDLE_FRAME;
        frame_start <= 1'b1;
        frame_done  <= (state == DATA_FRAME);
      end else begin
        cnt         <= cnt + CNT_W'(1);
        sreg        <= sreg << BYTE_W;
        frame_start <= 1'b0;
        frame_done  <= 1'b0;
      end
    end
  end

endmodule
